// File: rtl/process_images_kernel_acc.sv
// Kernel accumulator: sums TAPS signed products per pixel, rounds,
// shifts and clamps to an unsigned pixel on a valid/ready stream.
module process_images_kernel_acc #(
    parameter int PROD_WIDTH = 20,
    parameter int ACC_WIDTH  = 24,
    parameter int TAPS       = 9,
    parameter int SHIFT      = 4,
    parameter int PIX_WIDTH  = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [PROD_WIDTH-1:0] prod_tdata,
    input  logic                  prod_tuser,
    input  logic                  prod_tvalid,
    output logic                  prod_tready,
    output logic [PIX_WIDTH-1:0]  pix_tdata,
    output logic                  pix_tvalid,
    input  logic                  pix_tready,
    input  logic                  sat_clr,
    output logic [15:0]           sat_cnt,
    output logic                  frame_err
);

    localparam logic [7:0] LAST = 8'(TAPS - 1);
    localparam logic signed [ACC_WIDTH:0] RND =
        ((ACC_WIDTH+1)'(1) << SHIFT) >> 1;
    localparam logic signed [ACC_WIDTH:0] PMAX =
        (ACC_WIDTH+1)'((1 << PIX_WIDTH) - 1);

    logic signed [ACC_WIDTH-1:0] acc;
    logic [7:0]                  tap_cnt;

    logic                        accept;
    logic                        misalign;
    logic                        last_tap;
    logic signed [ACC_WIDTH-1:0] ext;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH-1:0] sum;
    logic [7:0]                  cur_tap;
    logic signed [ACC_WIDTH:0]   rsum;
    logic signed [ACC_WIDTH:0]   r;
    logic                        neg;
    logic                        over;
    logic [PIX_WIDTH-1:0]        pixel;

    assign prod_tready = !(pix_tvalid && !pix_tready);
    assign accept      = prod_tvalid && prod_tready;

    // A tuser mid-pixel restarts accumulation with this product as tap 0.
    assign misalign = prod_tuser && (tap_cnt != 8'd0);
    assign base     = misalign ? '0 : acc;
    assign cur_tap  = misalign ? 8'd0 : tap_cnt;
    assign last_tap = (cur_tap == LAST);

    assign ext  = {{(ACC_WIDTH-PROD_WIDTH){prod_tdata[PROD_WIDTH-1]}},
                   prod_tdata};
    assign sum  = base + ext;
    assign rsum = {sum[ACC_WIDTH-1], sum} + RND;
    assign r    = rsum >>> SHIFT;

    assign neg  = r[ACC_WIDTH];
    assign over = !neg && (r > PMAX);

    always_comb begin
        pixel = r[PIX_WIDTH-1:0];
        if (neg)
            pixel = '0;
        else if (over)
            pixel = '1;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            acc        <= '0;
            tap_cnt    <= '0;
            pix_tdata  <= '0;
            pix_tvalid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (pix_tvalid && pix_tready)
                pix_tvalid <= 1'b0;
            if (accept) begin
                if (misalign)
                    frame_err <= 1'b1;
                if (last_tap) begin
                    acc        <= '0;
                    tap_cnt    <= '0;
                    pix_tdata  <= pixel;
                    pix_tvalid <= 1'b1;
                end else begin
                    acc     <= sum;
                    tap_cnt <= cur_tap + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst)
            sat_cnt <= '0;
        else if (sat_clr)
            sat_cnt <= '0;
        else if (accept && last_tap && (neg || over) && sat_cnt != 16'hFFFF)
            sat_cnt <= sat_cnt + 16'd1;
    end

endmodule

// File: tb/tb_process_images_kernel_acc.sv
// Scoreboard bench for process_images_kernel_acc: directed pixels,
// clamps, rounding edges, backpressure, framing errors and reset.
module tb_process_images_kernel_acc;

    localparam int PW = 20;
    localparam int XW = 8;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic [PW-1:0] prod_tdata = '0;
    logic          prod_tuser = 1'b0;
    logic          prod_tvalid = 1'b0;
    logic          prod_tready;
    logic [XW-1:0] pix_tdata;
    logic          pix_tvalid;
    logic          pix_tready = 1'b1;
    logic          sat_clr = 1'b0;
    logic [15:0]   sat_cnt;
    logic          frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int exp_sat = 0;

    process_images_kernel_acc dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .prod_tdata  (prod_tdata),
        .prod_tuser  (prod_tuser),
        .prod_tvalid (prod_tvalid),
        .prod_tready (prod_tready),
        .pix_tdata   (pix_tdata),
        .pix_tvalid  (pix_tvalid),
        .pix_tready  (pix_tready),
        .sat_clr     (sat_clr),
        .sat_cnt     (sat_cnt),
        .frame_err   (frame_err)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expected pixel per observed transfer.
    always @(negedge ap_clk) begin
        if (!ap_rst && pix_tvalid && pix_tready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pixel: got %0d expected none",
                         pix_tdata);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(pix_tdata) != e) begin
                    n_err++;
                    $display("FAIL pixel: got %0d expected %0d",
                             pix_tdata, e);
                end
            end
        end
    end

    task automatic send(input int v, input bit u);
        bit done;
        int n;
        done = 1'b0;
        n = 0;
        prod_tdata  = PW'(v);
        prod_tuser  = u;
        prod_tvalid = 1'b1;
        while (!done) begin
            @(negedge ap_clk);
            if (prod_tready) done = 1'b1;
            @(posedge ap_clk);
            #1;
            n++;
            if (!done && n > 200) begin
                chk("send_timeout", 0, 1);
                done = 1'b1;
            end
        end
        prod_tvalid = 1'b0;
        prod_tuser  = 1'b0;
    endtask

    // Nine products: first value then eight copies of rest.
    task automatic pix9(input int first, input int rest, input int exp);
        for (int i = 0; i < 9; i++) begin
            if (i == 8) exp_q.push_back(exp);
            send(i == 0 ? first : rest, i == 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_pix_tvalid", int'(pix_tvalid), 0);
        chk("rst_pix_tdata", int'(pix_tdata), 0);
        chk("rst_sat_cnt", int'(sat_cnt), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_prod_tready", int'(prod_tready), 1);
        idle(2);
        ap_rst = 1'b0;
        idle(1);

        // Basic: sum 144 -> 9, visible right after the final accept.
        pix9(16, 16, 9);
        chk("lat_tvalid", int'(pix_tvalid), 1);
        chk("lat_tdata", int'(pix_tdata), 9);
        idle(2);
        chk("pulse_tvalid", int'(pix_tvalid), 0);
        chk("basic_sat", int'(sat_cnt), 0);

        pix9(-100, -100, 0);
        idle(2);
        chk("negclamp_sat", int'(sat_cnt), 1);

        pix9(524287, 524287, 255);
        idle(2);
        chk("posclamp_sat", int'(sat_cnt), 2);

        pix9(7, 0, 0);
        pix9(8, 0, 1);
        pix9(-8, 0, 0);
        idle(2);
        chk("round_m8_sat", int'(sat_cnt), 2);
        pix9(-9, 0, 0);
        idle(2);
        chk("round_m9_sat", int'(sat_cnt), 3);

        // Back-to-back pixels: 144 then 288.
        pix9(16, 16, 9);
        pix9(32, 32, 18);
        idle(2);

        // Backpressure with the next pixel's first product waiting.
        pix_tready = 1'b0;
        pix9(16, 16, 9);
        prod_tdata  = PW'(32);
        prod_tuser  = 1'b1;
        prod_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            chk("stall_prod_tready", int'(prod_tready), 0);
            chk("stall_tdata", int'(pix_tdata), 9);
        end
        @(posedge ap_clk);
        #1;
        pix_tready = 1'b1;
        pix9(32, 32, 18);
        idle(2);
        chk("bp_sat", int'(sat_cnt), 3);

        // Misalignment: tuser on tap 4 restarts the pixel.
        for (int i = 0; i < 4; i++) send(1000, i == 0);
        chk("pre_frame_err", int'(frame_err), 0);
        pix9(16, 16, 9);
        idle(2);
        chk("frame_err", int'(frame_err), 1);

        // sat_clr wins over a coincident clamp.
        for (int i = 0; i < 8; i++) send(-100, i == 0);
        exp_q.push_back(0);
        sat_clr = 1'b1;
        send(-100, 1'b0);
        sat_clr = 1'b0;
        idle(2);
        chk("satclr_sat", int'(sat_cnt), 0);

        // Reset mid-pixel discards the partial sum and clears status.
        pix9(-100, -100, 0);
        idle(2);
        chk("prereset_sat", int'(sat_cnt), 1);
        for (int i = 0; i < 4; i++) send(1000, i == 0);
        ap_rst = 1'b1;
        #1;
        chk("mid_rst_frame_err", int'(frame_err), 0);
        chk("mid_rst_sat", int'(sat_cnt), 0);
        chk("mid_rst_tvalid", int'(pix_tvalid), 0);
        idle(2);
        ap_rst = 1'b0;
        idle(1);
        pix9(16, 16, 9);
        idle(3);
        chk("post_rst_frame_err", int'(frame_err), 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
